// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the RAM1 SRAM / UART data bus between the instruction-fetch port
//   and the MEM-stage data port. Data accesses are served before fetch. When
//   both are requested, one DONE state completes both. Addresses 0xBF00
//   (UART data) and 0xBF01 (UART status) are decoded here.
//
// Ports
//   CLK, RST            clock, asynchronous active-low reset
//   ifReq/ifAddr        fetch request and address
//   ifData/ifValid      fetched word and its one-cycle completion pulse
//   memRead/memWrite    data request codes (01 or 10 active, other port 00)
//   memAddr/memDataIn   data address and write data
//   memDataOut/memDone  read data and its one-cycle completion pulse
//   stall               combinational pipeline freeze
//   ram1OE/WE/EN        SRAM strobes, active-low, registered
//   ram1Addr            {2'b00, addr}
//   ram1Data            shared SRAM/UART bus (tri-state)
//   tbre/tsre/data_ready UART status inputs
//   rdn/wrn             UART strobes, active-low, registered
module mem_arbiter (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ifReq,
   input  logic [15:0] ifAddr,
   output logic [15:0] ifData,
   output logic        ifValid,
   input  logic [1:0]  memRead,
   input  logic [1:0]  memWrite,
   input  logic [15:0] memAddr,
   input  logic [15:0] memDataIn,
   output logic [15:0] memDataOut,
   output logic        memDone,
   output logic        stall,
   output logic        ram1OE,
   output logic        ram1WE,
   output logic        ram1EN,
   output logic [17:0] ram1Addr,
   inout  wire  [15:0] ram1Data,
   input  logic        tbre,
   input  logic        tsre,
   input  logic        data_ready,
   output logic        rdn,
   output logic        wrn
);

   typedef enum logic [3:0] {
      S_IDLE, S_D_SET, S_D_STB, S_U_RD1, S_U_RD2, S_U_WR1, S_U_WR2,
      S_STAT, S_F_SET, S_F_STB, S_DONE
   } state_t;

   localparam logic [15:0] UART_DATA = 16'hBF00;
   localparam logic [15:0] UART_STAT = 16'hBF01;

   state_t      state_q, state_d;
   logic        is_wr_q, is_wr_d;     // current data access is a write
   logic        d_ran_q, d_ran_d;     // a data access ran in this sequence
   logic        f_ran_q, f_ran_d;     // a fetch ran in this sequence
   logic        oe_q, oe_d, we_q, we_d, en_q, en_d;
   logic        rdn_q, rdn_d, wrn_q, wrn_d;
   logic        drive_q, drive_d;
   logic [17:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] mdo_q, mdo_d, ifd_q, ifd_d;
   logic        d_rd, d_wr;

   assign d_rd = (memRead == 2'b01 || memRead == 2'b10) && memWrite == 2'b00;
   assign d_wr = (memWrite == 2'b01 || memWrite == 2'b10) && memRead == 2'b00;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (d_rd || d_wr) begin
               if (memAddr == UART_DATA)         state_d = d_rd ? S_U_RD1 : S_U_WR1;
               else if (d_rd && memAddr == UART_STAT) state_d = S_STAT;
               else                              state_d = S_D_SET;
            end else if (ifReq) begin
               state_d = S_F_SET;
            end
         end
         S_D_SET: state_d = S_D_STB;
         S_U_RD1: state_d = S_U_RD2;
         S_U_WR1: state_d = S_U_WR2;
         S_D_STB, S_U_RD2, S_U_WR2, S_STAT: state_d = ifReq ? S_F_SET : S_DONE;
         S_F_SET: state_d = S_F_STB;
         S_F_STB: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Sequence bookkeeping and registered strobes. Strobes are computed from
   // the next state so the flop outputs line up with the current state.
   always_comb begin
      is_wr_d = is_wr_q;
      d_ran_d = d_ran_q;
      f_ran_d = f_ran_q;
      wdata_d = wdata_q;
      if (state_q == S_IDLE) begin
         is_wr_d = d_wr;
         d_ran_d = d_rd | d_wr;
         f_ran_d = 1'b0;
         wdata_d = memDataIn;
      end
      if (state_d == S_F_SET) f_ran_d = 1'b1;

      oe_d    = 1'b1;
      we_d    = 1'b1;
      en_d    = 1'b1;
      rdn_d   = 1'b1;
      wrn_d   = 1'b1;
      drive_d = 1'b0;
      addr_d  = addr_q;
      case (state_d)
         S_D_SET: begin
            en_d    = 1'b0;
            addr_d  = {2'b00, memAddr};
            drive_d = is_wr_d;
         end
         S_D_STB: begin
            oe_d    = is_wr_d;
            we_d    = ~is_wr_d;
            drive_d = is_wr_d;
         end
         S_F_SET: begin
            en_d   = 1'b0;
            addr_d = {2'b00, ifAddr};
         end
         S_F_STB: oe_d = 1'b0;
         S_U_RD1, S_U_RD2: rdn_d = 1'b0;
         S_U_WR1: begin
            wrn_d   = 1'b0;
            drive_d = 1'b1;
         end
         S_U_WR2: drive_d = 1'b1;
         default: ;
      endcase
   end

   // Read capture on the final cycle of each read phase
   always_comb begin
      mdo_d = mdo_q;
      ifd_d = ifd_q;
      case (state_q)
         S_D_STB: if (!is_wr_q) mdo_d = ram1Data;
         S_U_RD2: mdo_d = ram1Data;
         S_STAT:  mdo_d = {14'b0, data_ready, tbre & tsre};
         S_F_STB: ifd_d = ram1Data;
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         is_wr_q <= 1'b0;
         d_ran_q <= 1'b0;
         f_ran_q <= 1'b0;
         oe_q    <= 1'b1;
         we_q    <= 1'b1;
         en_q    <= 1'b1;
         rdn_q   <= 1'b1;
         wrn_q   <= 1'b1;
         drive_q <= 1'b0;
         addr_q  <= 18'd0;
         wdata_q <= 16'd0;
         mdo_q   <= 16'd0;
         ifd_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         is_wr_q <= is_wr_d;
         d_ran_q <= d_ran_d;
         f_ran_q <= f_ran_d;
         oe_q    <= oe_d;
         we_q    <= we_d;
         en_q    <= en_d;
         rdn_q   <= rdn_d;
         wrn_q   <= wrn_d;
         drive_q <= drive_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mdo_q   <= mdo_d;
         ifd_q   <= ifd_d;
      end
   end

   // Stall is combinational so the pipeline freezes in the request cycle;
   // DONE releases it for exactly one cycle while the results are presented.
   always_comb begin
      stall = 1'b1;
      if (!RST)                   stall = 1'b0;
      else if (state_q == S_IDLE) stall = d_rd | d_wr | ifReq;
      else if (state_q == S_DONE) stall = 1'b0;
   end

   assign ram1Data   = drive_q ? wdata_q : 16'bz;
   assign ram1OE     = oe_q;
   assign ram1WE     = we_q;
   assign ram1EN     = en_q;
   assign ram1Addr   = addr_q;
   assign rdn        = rdn_q;
   assign wrn        = wrn_q;
   assign memDataOut = mdo_q;
   assign ifData     = ifd_q;
   assign memDone    = (state_q == S_DONE) & d_ran_q;
   assign ifValid    = (state_q == S_DONE) & f_ran_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic        CLK, RST;
   logic        ifReq;
   logic [15:0] ifAddr;
   logic [15:0] ifData;
   logic        ifValid;
   logic [1:0]  memRead, memWrite;
   logic [15:0] memAddr, memDataIn, memDataOut;
   logic        memDone, stall;
   logic        ram1OE, ram1WE, ram1EN;
   logic [17:0] ram1Addr;
   tri1  [15:0] ram1Data;   // floating bus reads back as all ones
   logic        tbre, tsre, data_ready;
   logic        rdn, wrn;

   mem_arbiter dut (
      .CLK(CLK), .RST(RST),
      .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData), .ifValid(ifValid),
      .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr),
      .memDataIn(memDataIn), .memDataOut(memDataOut), .memDone(memDone),
      .stall(stall), .ram1OE(ram1OE), .ram1WE(ram1WE), .ram1EN(ram1EN),
      .ram1Addr(ram1Addr), .ram1Data(ram1Data),
      .tbre(tbre), .tsre(tsre), .data_ready(data_ready), .rdn(rdn), .wrn(wrn)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- board model: SRAM and UART ----------------
   logic [15:0] mem [0:65535];
   logic [15:0] uart_rx, uart_tx;

   function automatic logic [15:0] init_word(input int a);
      logic [15:0] w;
      w = 16'(a) ^ 16'hA5C3;
      if (a == 16'h0010) w = 16'h4A21;
      return w;
   endfunction

   assign ram1Data = !ram1OE ? mem[ram1Addr[15:0]] : (!rdn ? uart_rx : 16'bz);

   // Writes are captured mid-cycle, well away from the strobe edges.
   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = init_word(i);
      uart_tx = 16'h0;
      forever begin
         @(negedge CLK);
         if (!ram1WE) mem[ram1Addr[15:0]] = ram1Data;
         if (!wrn)    uart_tx = ram1Data;
      end
   end

   // ---------------- checking ----------------
   int n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  rd, wr;
      logic [15:0] maddr, mdin;
      logic        ifreq;
      logic [15:0] iaddr, urx;
      logic        dr, tb, ts;
   } stim_t;
   typedef struct {
      int          lat;
      logic        md, iv;
      logic [15:0] mdo, ifd;
   } res_t;
   typedef struct {
      int oe, we, en, rdn, wrn;
      bit sram, sram_wr, uart_wr;
   } cnt_t;
   typedef struct { stim_t s; res_t r; } vec_t;

   // ---------------- reference model ----------------
   logic [15:0] ref_mem [0:65535];
   logic [15:0] h_mdo, h_ifd;   // values the output ports should be holding

   task automatic predict(input stim_t s, output res_t r, output cnt_t c);
      bit drd, dwr, uart, stat, sram;
      int dcyc;
      drd  = (s.rd == 2'd1 || s.rd == 2'd2) && s.wr == 2'd0;
      dwr  = (s.wr == 2'd1 || s.wr == 2'd2) && s.rd == 2'd0;
      uart = (drd || dwr) && s.maddr == 16'hBF00;
      stat = drd && s.maddr == 16'hBF01;
      sram = (drd || dwr) && !uart && !stat;
      dcyc = (sram || uart) ? 2 : (stat ? 1 : 0);
      r.lat = (drd || dwr || s.ifreq) ? 1 + dcyc + (s.ifreq ? 2 : 0) : 0;
      if (sram && dwr) ref_mem[s.maddr] = s.mdin;
      if (sram && drd) h_mdo = ref_mem[s.maddr];
      if (uart && drd) h_mdo = s.urx;
      if (stat)        h_mdo = {14'b0, s.dr, s.tb & s.ts};
      if (s.ifreq)     h_ifd = ref_mem[s.iaddr];
      r.md  = drd || dwr;
      r.iv  = s.ifreq;
      r.mdo = h_mdo;
      r.ifd = h_ifd;
      c.oe  = int'(sram && drd) + int'(s.ifreq);
      c.we  = int'(sram && dwr);
      c.en  = int'(sram) + int'(s.ifreq);
      c.rdn = (uart && drd) ? 2 : 0;
      c.wrn = (uart && dwr) ? 1 : 0;
      c.sram = sram;
      c.sram_wr = sram && dwr;
      c.uart_wr = uart && dwr;
   endtask

   function automatic vec_t mk(input logic [1:0] rd, wr, input logic [15:0] ma, md,
                               input logic fr, input logic [15:0] fa, urx,
                               input logic dr, tb, ts, input int lat,
                               input logic emd, eiv, input logic [15:0] emdo, eifd);
      vec_t v;
      v.s.rd = rd; v.s.wr = wr; v.s.maddr = ma; v.s.mdin = md;
      v.s.ifreq = fr; v.s.iaddr = fa; v.s.urx = urx;
      v.s.dr = dr; v.s.tb = tb; v.s.ts = ts;
      v.r.lat = lat; v.r.md = emd; v.r.iv = eiv; v.r.mdo = emdo; v.r.ifd = eifd;
      return v;
   endfunction

   // One request, applied in IDLE, followed to its DONE cycle.
   task automatic run_txn(input stim_t s, input bit use_tab, input res_t tab);
      res_t m, ex;
      cnt_t c;
      int n, lim, oe, we, en, nr, nw, st;
      bit seen;
      logic [17:0] a_first, a_last;
      predict(s, m, c);
      ex = use_tab ? tab : m;
      @(negedge CLK);
      memRead = s.rd; memWrite = s.wr; memAddr = s.maddr; memDataIn = s.mdin;
      ifReq = s.ifreq; ifAddr = s.iaddr; uart_rx = s.urx;
      data_ready = s.dr; tbre = s.tb; tsre = s.ts;
      #1;
      chk("stall_req", stall, (ex.lat != 0));
      n = 0; seen = 0; oe = 0; we = 0; en = 0; nr = 0; nw = 0; st = 0;
      a_first = '0; a_last = '0;
      lim = (ex.lat == 0) ? 4 : 12;
      while (!seen && n < lim) begin
         @(posedge CLK); #1;
         n++;
         if (memDone || ifValid) seen = 1;
         if (!ram1OE) oe++;
         if (!rdn) nr++;
         if (stall) st++;
         if (!ram1WE) begin we++; chk("we_bus", ram1Data, s.mdin); end
         if (!wrn)    begin nw++; chk("wrn_bus", ram1Data, s.mdin); end
         if (!ram1EN) begin
            if (en == 0) a_first = ram1Addr;
            a_last = ram1Addr;
            en++;
         end
      end
      chk("latency", seen ? n : 0, ex.lat);
      chk("oe_cycles", oe, c.oe);
      chk("we_cycles", we, c.we);
      chk("en_cycles", en, c.en);
      chk("rdn_cycles", nr, c.rdn);
      chk("wrn_cycles", nw, c.wrn);
      chk("stall_cycles", st, (ex.lat > 0) ? ex.lat - 1 : 0);
      if (c.en > 0) begin
         chk("addr_first", a_first, {2'b00, c.sram ? s.maddr : s.iaddr});
         chk("addr_last", a_last, {2'b00, s.ifreq ? s.iaddr : s.maddr});
      end
      if (seen) begin
         chk("memDone", memDone, ex.md);
         chk("ifValid", ifValid, ex.iv);
         chk("stall_done", stall, 0);
         chk("bus_released", ram1Data, 16'hFFFF);
      end
      chk("memDataOut", memDataOut, ex.mdo);
      chk("ifData", ifData, ex.ifd);
      if (c.sram_wr) chk("sram_written", mem[s.maddr], s.mdin);
      if (c.uart_wr) chk("uart_tx", uart_tx, s.mdin);
      @(negedge CLK);
      memRead = 0; memWrite = 0; ifReq = 0;
      @(posedge CLK); #1;
      chk("pulse_width", {memDone, ifValid}, 2'b00);
      chk("mdo_held", memDataOut, ex.mdo);
   endtask

   vec_t  tab [12];
   stim_t s;
   res_t  r, dummy;
   cnt_t  c;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
      h_mdo = 16'h0; h_ifd = 16'h0;
      dummy = '{lat: 0, md: 0, iv: 0, mdo: 0, ifd: 0};
      RST = 0; ifReq = 1; ifAddr = 16'h0010;
      memRead = 0; memWrite = 0; memAddr = 0; memDataIn = 0;
      tbre = 0; tsre = 0; data_ready = 0; uart_rx = 0;

      // Reset held with ifReq pending
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_strobes", {ram1OE, ram1WE, ram1EN, rdn, wrn}, 5'b11111);
      chk("rst_stall", stall, 0);
      chk("rst_bus", ram1Data, 16'hFFFF);
      chk("rst_addr", ram1Addr, 0);
      chk("rst_outs", {memDone, ifValid, memDataOut, ifData}, 34'h0);
      @(negedge CLK); RST = 1; #1;
      chk("stall_after_rst", stall, 1);
      s = '{rd: 0, wr: 0, maddr: 0, mdin: 0, ifreq: 1, iaddr: 16'h0010,
            urx: 0, dr: 0, tb: 0, ts: 0};
      predict(s, r, c);
      @(posedge CLK); #1;
      chk("fset_en", ram1EN, 0);
      chk("fset_addr", ram1Addr, 18'h00010);
      @(posedge CLK); #1;
      chk("fstb_oe", ram1OE, 0);
      @(posedge CLK); #1;
      chk("first_fetch_valid", {ifValid, memDone}, 2'b10);
      chk("first_fetch_data", ifData, r.ifd);
      @(negedge CLK); ifReq = 0;
      @(posedge CLK); #1;
      chk("first_fetch_pulse", ifValid, 0);

      // Directed table (rd, wr, maddr, mdin, ifreq, iaddr, urx, dr, tbre, tsre | lat, md, iv, mdo, ifd)
      tab[0]  = mk(0, 0, 16'h0000, 16'h0000, 1, 16'h0010, 16'h0000, 0, 0, 0, 3, 0, 1, 16'h0000, 16'h4A21);
      tab[1]  = mk(0, 1, 16'h8000, 16'hBEEF, 1, 16'h0010, 16'h0000, 0, 0, 0, 5, 1, 1, 16'h0000, 16'h4A21);
      tab[2]  = mk(1, 0, 16'h8000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 3, 1, 0, 16'hBEEF, 16'h4A21);
      tab[3]  = mk(1, 0, 16'hBF01, 16'h0000, 0, 16'h0000, 16'h0000, 1, 1, 1, 2, 1, 0, 16'h0003, 16'h4A21);
      tab[4]  = mk(2, 0, 16'hBF01, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 0, 2, 1, 0, 16'h0000, 16'h4A21);
      tab[5]  = mk(0, 2, 16'hBF00, 16'h0041, 0, 16'h0000, 16'h0000, 0, 0, 0, 3, 1, 0, 16'h0000, 16'h4A21);
      tab[6]  = mk(3, 0, 16'h0010, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h4A21);
      tab[7]  = mk(1, 0, 16'hBF00, 16'h0000, 1, 16'h8000, 16'h1234, 0, 0, 0, 5, 1, 1, 16'h1234, 16'hBEEF);
      tab[8]  = mk(1, 1, 16'h0010, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h1234, 16'hBEEF);
      tab[9]  = mk(2, 0, 16'h0010, 16'h0000, 1, 16'h0010, 16'h0000, 0, 0, 0, 5, 1, 1, 16'h4A21, 16'h4A21);
      tab[10] = mk(1, 0, 16'hBF01, 16'h0000, 1, 16'h8000, 16'h0000, 1, 0, 1, 4, 1, 1, 16'h0002, 16'hBEEF);
      tab[11] = mk(0, 2, 16'hBF01, 16'h7777, 0, 16'h0000, 16'h0000, 0, 0, 0, 3, 1, 0, 16'h0002, 16'hBEEF);
      for (int i = 0; i < 12; i++) run_txn(tab[i].s, 1, tab[i].r);

      // Randomized traffic against the reference model
      for (int i = 0; i < 40; i++) begin
         s.rd = 2'($urandom_range(0, 3));
         s.wr = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) begin
            if ($urandom_range(0, 1) != 0) s.rd = 2'd0; else s.wr = 2'd0;
         end
         case ($urandom_range(0, 3))
            0:       s.maddr = 16'hBF00;
            1:       s.maddr = 16'hBF01;
            default: s.maddr = {8'h00, 8'($urandom)};
         endcase
         s.mdin  = 16'($urandom);
         s.ifreq = 1'($urandom_range(0, 1));
         s.iaddr = {8'h00, 8'($urandom)};
         s.urx   = 16'($urandom);
         s.dr = 1'($urandom); s.tb = 1'($urandom); s.ts = 1'($urandom);
         run_txn(s, 0, dummy);
      end

      // Reset pulled during the strobe cycle of an SRAM write
      @(negedge CLK);
      memWrite = 2'b01; memAddr = 16'h0020; memDataIn = 16'h1111; ifReq = 0;
      @(posedge CLK); #1;
      chk("abort_dset_en", ram1EN, 0);
      @(posedge CLK); #1;
      chk("abort_dstb_we", ram1WE, 0);
      chk("abort_dstb_bus", ram1Data, 16'h1111);
      RST = 0; #1;
      chk("abort_strobes", {ram1OE, ram1WE, ram1EN, rdn, wrn}, 5'b11111);
      chk("abort_bus", ram1Data, 16'hFFFF);
      chk("abort_stall", stall, 0);
      @(negedge CLK); memWrite = 0;
      @(negedge CLK); RST = 1;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
         chk("abort_no_done", {memDone, ifValid}, 2'b00);
      end
      chk("abort_sram_unchanged", mem[16'h0020], ref_mem[16'h0020]);
      h_mdo = 16'h0; h_ifd = 16'h0;
      chk("abort_outs_reset", {memDataOut, ifData}, 32'h0);
      s = '{rd: 0, wr: 0, maddr: 0, mdin: 0, ifreq: 1, iaddr: 16'h0020,
            urx: 0, dr: 0, tb: 0, ts: 0};
      run_txn(s, 0, dummy);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single RAM1 SRAM / UART data bus between the pipeline's instruction-fetch port and its MEM-stage data port, and sequences every physical access. It sits between the CPU pipeline and the board pins. It drives the pipeline-wide stall, gives data accesses priority over fetch, and decodes the UART data/status addresses 0xBF00 and 0xBF01.

## Interface
- No parameters.
- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- ifReq  in  1  fetch request; held stable while stall=1.
- ifAddr  in  16  fetch address.
- ifData  out  16  fetched instruction; valid when ifValid=1, held otherwise.
- ifValid  out  1  one-cycle fetch-complete pulse.
- memRead  in  2  data read request; 2'b01 or 2'b10 means read.
- memWrite  in  2  data write request; 2'b01 or 2'b10 means write.
- memAddr  in  16  data address.
- memDataIn  in  16  write data.
- memDataOut  out  16  read data; valid when memDone=1, held otherwise.
- memDone  out  1  one-cycle data-complete pulse.
- stall  out  1  freezes the pipeline, combinational.
- ram1OE, ram1WE, ram1EN  out  1 each  SRAM strobes, active-low.
- ram1Addr  out  18  {2'b00, addr}.
- ram1Data  inout  16  shared SRAM/UART data bus.
- tbre, tsre, data_ready  in  1 each  UART status.
- rdn, wrn  out  1 each  UART strobes, active-low.

## Operation
- Data request: dRd = memRead∈{01,10} && memWrite==00; dWr = memWrite∈{01,10} && memRead==00. Any other combination is no request.
- States: IDLE, D_SET, D_STB, U_RD1, U_RD2, U_WR1, U_WR2, STAT, F_SET, F_STB, DONE.
- IDLE dispatch rules:
  - dRd or dWr with memAddr=0xBF00 → U_RD1 (read) or U_WR1 (write).
  - dRd with memAddr=0xBF01 → STAT.
  - Any other dRd or dWr → D_SET.
  - ifReq alone → F_SET.
  - No request → IDLE.
- Data phases (D_STB, U_RD2, U_WR2, STAT) go to F_SET if ifReq is still high, else to DONE.
- F_STB → DONE. DONE → IDLE; requests are ignored while in DONE.
- Strobes per state (all unlisted strobes are 1):
  - D_SET and F_SET: ram1EN=0, ram1Addr loaded.
  - D_STB: ram1OE=0 (read) or ram1WE=0 (write). F_STB: ram1OE=0.
  - U_RD1 and U_RD2: ram1EN=1, rdn=0.
  - U_WR1: wrn=0. U_WR2: wrn=1.
- ram1Data is driven with memDataIn only in D_SET/D_STB for a write and in U_WR1/U_WR2; it is Z at all other times.
- Read capture:
  - memDataOut ← ram1Data at the end of D_STB (read) and U_RD2.
  - memDataOut ← {14'b0, data_ready, tbre&tsre} at the end of STAT.
  - ifData ← ram1Data at the end of F_STB.
- DONE: memDone=1 if a data access ran, ifValid=1 if a fetch ran. Both may be 1 together.
- stall = 1 in every state except IDLE and DONE; in IDLE, stall = (dRd|dWr|ifReq); in DONE, stall = 0.
- The block does not check UART readiness; software polls 0xBF01 before accessing 0xBF00.

## Timing
- Reset values: ram1OE=ram1WE=ram1EN=1, ram1Addr=0, rdn=wrn=1, ram1Data=Z, ifData=memDataOut=0, ifValid=memDone=0, state=IDLE. stall is forced to 0 while RST=0.
- Latency from the IDLE sample to DONE:
  - Fetch only: 3 cycles.
  - SRAM data only: 3 cycles. UART data: 3 cycles. Status read: 2 cycles.
  - SRAM data plus fetch: 5 cycles.
- Simultaneous data and fetch requests: data is always served first, and a single DONE completes both.
- Reset asserted mid-access: all strobes return to 1 immediately (asynchronous), the bus goes to Z, the access is aborted, and no done pulse is issued.
- SRAM strobes are registered, so there are no glitches; the address is stable for the whole access.

## Test plan
- Reset with ifReq=1 held → all strobes 1, stall=0, ram1Data=Z; after release, F_SET at the first edge.
- ifReq=1, ifAddr=0x0010, SRAM[0x10]=0x4A21 → ram1OE=0 in F_STB only; ifData=0x4A21, ifValid=1 three cycles later.
- memWrite=01, memAddr=0x8000, memDataIn=0xBEEF, ifReq=1 → ram1WE=0 for one cycle with 0xBEEF on the bus, then fetch; DONE with memDone=ifValid=1 at cycle 5.
- memRead=01, memAddr=0xBF01, data_ready=1, tbre=tsre=1 → memDataOut=0x0003 after 2 cycles with no SRAM strobe.
- memWrite=10, memAddr=0xBF00, memDataIn=0x0041 → wrn low one cycle then high, ram1EN=1, bus=0x0041 across both cycles; memRead=11 with memWrite=00 → treated as no request.
- RST pulled low during D_STB of a write → ram1WE=1 and the bus goes to Z immediately; no memDone pulse.
